// File: rtl/fnd_pkg.sv
// Shared types and constants for the FND digit scanner.
package fnd_pkg;

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} fnd_state_e;

  // One 1 ms digit slot at the 100 MHz board clock.
  localparam int FND_CLK_DIV_DEFAULT = 100000;

  // Level an inactive digit pin is driven to.
  function automatic logic FND_DIGIT_OFF(input bit active_low);
    return active_low;
  endfunction

endpackage

// File: rtl/fnd_onehot_decoder.sv
// Index to one-hot digit enable with enable gate and output polarity.
module fnd_onehot_decoder import fnd_pkg::*; #(
  parameter int NUM        = 4,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                   i_en,
  input  logic [$clog2(NUM)-1:0] i_idx,
  output logic [NUM-1:0]         o_onehot
);

  localparam int IW = $clog2(NUM);

  for (genvar d = 0; d < NUM; d++) begin : g_bit
    assign o_onehot[d] = (i_en && i_idx == IW'(d)) ? ~FND_DIGIT_OFF(ACTIVE_LOW)
                                                  :  FND_DIGIT_OFF(ACTIVE_LOW);
  end

endmodule

// File: rtl/fnd_digit_scanner.sv
// Multiplexed FND digit scanner: slot timer, blank/show FSM and digit index,
// all outputs registered from next-state so o_digit and o_digit_sel stay aligned.
module fnd_digit_scanner import fnd_pkg::*; #(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = FND_CLK_DIV_DEFAULT,
  parameter int BLANK_CYCLES = 16,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic                          i_enable,
  input  logic [NUM_DIGITS-1:0]         i_digit_mask,
  output logic [NUM_DIGITS-1:0]         o_digit,
  output logic [$clog2(NUM_DIGITS)-1:0] o_digit_sel,
  output logic                          o_scan_tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [SW-1:0] SEL_LAST   = SW'(NUM_DIGITS - 1);
  localparam fnd_state_e    SLOT_START = (BLANK_CYCLES == 0) ? SHOW : BLANK;

  fnd_state_e            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [SW-1:0]         sel_q, sel_d;
  logic                  tick_q, tick_d;
  logic [NUM_DIGITS-1:0] digit_q, digit_d;
  logic                  show_en;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    tick_d  = 1'b0;
    if (!i_enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = SLOT_START;
          cnt_d   = '0;
          tick_d  = 1'b1;
        end
        default: begin
          if (cnt_q == CNT_LAST) begin
            state_d = SLOT_START;
            cnt_d   = '0;
            sel_d   = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
            tick_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
            if (state_q == BLANK && cnt_q == BLANK_LAST) state_d = SHOW;
          end
        end
      endcase
    end
  end

  // Decoding the next index/state keeps a mask change at a slot end on the new digit.
  assign show_en = (state_d == SHOW) && !i_digit_mask[sel_d];

  fnd_onehot_decoder #(
    .NUM        (NUM_DIGITS),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_dec (
    .i_en     (show_en),
    .i_idx    (sel_d),
    .o_onehot (digit_d)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      tick_q  <= 1'b0;
      digit_q <= {NUM_DIGITS{FND_DIGIT_OFF(ACTIVE_LOW)}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      tick_q  <= tick_d;
      digit_q <= digit_d;
    end
  end

  assign o_digit     = digit_q;
  assign o_digit_sel = sel_q;
  assign o_scan_tick = tick_q;

endmodule
